mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 16-bit pipeline. It sits between the EX/MEM pipeline registers and the write-back stage. It owns the data memory and performs loads and stores with a fixed multi-cycle access latency, stalling upstream while an access is in flight. Its registered outputs feed the write-back stage's `alu_res`, `mem_res`, `mem_wb_dest`, `alu_bar_mem` and `wb_en` inputs directly.

## Interface
- `ADDR_W`, default 8: word-address width; data memory depth is 2^ADDR_W 16-bit words.
- `MEM_LAT`, default 2: access latency in cycles. Must be ≥1; elaboration fails otherwise.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `ex_valid`, in, 1: the `ex_*` fields carry an instruction.
- `ex_alu_res`, in, 16: ALU result; this is the word address for loads and stores.
- `ex_store_data`, in, 16: store data.
- `ex_dest`, in, 3: destination register.
- `ex_mem_read`, in, 1: the instruction is a load.
- `ex_mem_write`, in, 1: the instruction is a store.
- `ex_wb_en`, in, 1: the instruction writes back.
- `stall`, out, 1: combinational; upstream holds the `ex_*` inputs stable while this is high.
- `alu_res`, out, 16: to write-back.
- `mem_res`, out, 16: load data, to write-back.
- `mem_wb_dest`, out, 3: destination register, to write-back.
- `alu_bar_mem`, out, 1: 0 selects the ALU result, 1 selects load data.
- `wb_en`, out, 1: write-back enable.

## Operation
- FSM states:
  - IDLE: accepting instructions.
  - BUSY: a memory access is in flight; the `ex_*` inputs are ignored.
- The memory op is `ex_mem_read | ex_mem_write`. If both are set, the instruction is a store.
- IDLE with `ex_valid=0` → bubble: all output registers are loaded with 0 at the next edge.
- IDLE with a valid non-memory instruction, at the next edge:
  - `alu_res`←`ex_alu_res`, `mem_wb_dest`←`ex_dest`, `wb_en`←`ex_wb_en`;
  - `alu_bar_mem`←0, `mem_res`←0.
- IDLE with a valid memory op:
  - `stall`=1 in that cycle;
  - the address, data, dest, op type and `wb_en` are captured into holding registers;
  - `cnt`←MEM_LAT-1, next state BUSY;
  - the outputs receive a bubble.
- BUSY with `cnt`≠0: `stall`=1, `cnt` decrements, outputs receive a bubble.
- BUSY with `cnt`=0 (completion cycle): `stall`=0, next state IDLE.
  - Load: `mem_res`←mem[addr], `alu_res`←held address value, `mem_wb_dest`←held dest, `alu_bar_mem`←1, `wb_en`←held `wb_en`.
  - Store: mem[addr]←held data; all outputs 0 (`wb_en`=0 regardless of `ex_wb_en`).
- Address = `ex_alu_res[ADDR_W-1:0]`. Upper bits are ignored, so addresses wrap modulo the memory depth.
- The data memory is not cleared by reset. Reads of never-written words are undefined.

## Timing
- Reset (edge with `rst`=1): state IDLE, `cnt`=0, every output register 0, holding registers 0. `stall` is forced to 0 while `rst`=1.
- Reset during BUSY aborts the access; no memory write occurs.
- Non-memory instruction: latency 1 edge, `stall` never asserted.
- Memory instruction accepted in cycle 0:
  - `stall` is high in cycles 0…MEM_LAT-1;
  - the access completes in cycle MEM_LAT;
  - the result is visible on the outputs after edge MEM_LAT, i.e. MEM_LAT+1 edges after presentation.
- In the completion cycle the upstream still presents the same memory instruction. The block ignores it because it is in BUSY, and upstream advances at that edge.
- Back-to-back memory ops: the second is accepted in the cycle after completion (IDLE). There is no idle gap on the outputs beyond the stall bubbles.
- A store followed by a load to the same address returns the stored data, because the write lands in the store's completion cycle.

## Structure
- Shared package `mips_pkg` holds:
  - `DATA_W`=16 and `DEST_W`=3;
  - the state enum {IDLE, BUSY}.
- One sub-module: `data_mem`, 2^ADDR_W×16, with combinational read and synchronous write gated by `we`. `mem_stage` instantiates it and registers the read data into `mem_res`.
- Counter width is `$clog2(MEM_LAT)` with a minimum of 1.

## Test plan
- Reset then ALU op: `ex_alu_res`=0x1234, dest 5, `wb_en`=1 → next cycle `alu_res`=0x1234, `mem_wb_dest`=5, `alu_bar_mem`=0, `wb_en`=1, `stall` never high.
- MEM_LAT=2: store 0xBEEF to addr 0x10, then load addr 0x10 to dest 3 →
  - `stall` high 2 cycles for each op;
  - store outputs `wb_en`=0;
  - load outputs `mem_res`=0xBEEF, `alu_bar_mem`=1, `mem_wb_dest`=3, `wb_en`=1 exactly 3 edges after the load is presented.
- Address wrap (ADDR_W=8): store 0x0A0A to `ex_alu_res`=0x0105, then load 0x0005 → returns 0x0A0A.
- `ex_mem_read`=`ex_mem_write`=1 with data 0x7777, addr 0x20, `ex_wb_en`=1 → treated as store: `wb_en`=0, and a later load of 0x20 returns 0x7777.
- Assert `rst` in the first BUSY cycle of a store of 0x5555 to addr 0x30 (addr pre-loaded with 0x1111) → all outputs 0, `stall`=0, state IDLE; a later load of 0x30 returns 0x1111.
- Interleaved bubbles (`ex_valid`=0) between ops → outputs all 0 in bubble cycles; MEM_LAT=1 load gives `stall` for exactly 1 cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths and FSM state type for the 16-bit pipeline
package mips_pkg;

  localparam int DATA_W = 16;
  localparam int DEST_W = 3;

  // Memory-stage access FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - data memory, combinational read, synchronous gated write
module data_mem
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; software must write before reading
  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Write port: a single word lands on the edge where we is high
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage with fixed-latency data memory access
module mem_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [DEST_W-1:0] ex_dest,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_wb_en,
  output logic              stall,
  output logic [DATA_W-1:0] alu_res,
  output logic [DATA_W-1:0] mem_res,
  output logic [DEST_W-1:0] mem_wb_dest,
  output logic              alu_bar_mem,
  output logic              wb_en
);

  // A zero latency would make the completion cycle coincide with acceptance
  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_stage: MEM_LAT must be at least 1");
  end

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Captured copy of the accepted memory instruction
  logic [DATA_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [DEST_W-1:0] hold_dest_q, hold_dest_d;
  logic              hold_store_q, hold_store_d;
  logic              hold_wb_en_q, hold_wb_en_d;

  // Output registers facing write-back
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [DATA_W-1:0] mem_res_q, mem_res_d;
  logic [DEST_W-1:0] dest_q, dest_d;
  logic              alu_bar_mem_q, alu_bar_mem_d;
  logic              wb_en_q, wb_en_d;

  logic              ex_mem_op;
  logic              mem_we_c;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign ex_mem_op = ex_mem_read | ex_mem_write;

  // Memory is always addressed from the holding register, so the read data is
  // stable during the completion cycle regardless of what upstream presents
  data_mem #(
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (hold_addr_q[ADDR_W-1:0]),
    .wdata (hold_data_q),
    .rdata (mem_rdata)
  );

  // A reset landing on the completion cycle must not let the store through
  assign mem_we = mem_we_c & ~rst;

  // Upstream hold request: accepting a memory op, or waiting out the latency
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      if (state_q == IDLE) begin
        stall = ex_valid & ex_mem_op;
      end else begin
        stall = (cnt_q != '0);
      end
    end
  end

  // Next-state, capture and output selection; outputs default to a bubble
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    hold_addr_d   = hold_addr_q;
    hold_data_d   = hold_data_q;
    hold_dest_d   = hold_dest_q;
    hold_store_d  = hold_store_q;
    hold_wb_en_d  = hold_wb_en_q;
    alu_res_d     = '0;
    mem_res_d     = '0;
    dest_d        = '0;
    alu_bar_mem_d = 1'b0;
    wb_en_d       = 1'b0;
    mem_we_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_mem_op) begin
            hold_addr_d  = ex_alu_res;
            hold_data_d  = ex_store_data;
            hold_dest_d  = ex_dest;
            // Read and write together resolves to a store
            hold_store_d = ex_mem_write;
            hold_wb_en_d = ex_wb_en;
            cnt_d        = CNT_LOAD;
            state_d      = BUSY;
          end else begin
            alu_res_d = ex_alu_res;
            dest_d    = ex_dest;
            wb_en_d   = ex_wb_en;
          end
        end
      end

      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          if (hold_store_q) begin
            mem_we_c = 1'b1;
          end else begin
            alu_res_d     = hold_addr_q;
            mem_res_d     = mem_rdata;
            dest_d        = hold_dest_q;
            alu_bar_mem_d = 1'b1;
            wb_en_d       = hold_wb_en_q;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, holding and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_addr_q   <= '0;
      hold_data_q   <= '0;
      hold_dest_q   <= '0;
      hold_store_q  <= 1'b0;
      hold_wb_en_q  <= 1'b0;
      alu_res_q     <= '0;
      mem_res_q     <= '0;
      dest_q        <= '0;
      alu_bar_mem_q <= 1'b0;
      wb_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_addr_q   <= hold_addr_d;
      hold_data_q   <= hold_data_d;
      hold_dest_q   <= hold_dest_d;
      hold_store_q  <= hold_store_d;
      hold_wb_en_q  <= hold_wb_en_d;
      alu_res_q     <= alu_res_d;
      mem_res_q     <= mem_res_d;
      dest_q        <= dest_d;
      alu_bar_mem_q <= alu_bar_mem_d;
      wb_en_q       <= wb_en_d;
    end
  end

  assign alu_res     = alu_res_q;
  assign mem_res     = mem_res_q;
  assign mem_wb_dest = dest_q;
  assign alu_bar_mem = alu_bar_mem_q;
  assign wb_en       = wb_en_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage at two latencies
module tb_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        ex_valid;
  logic [15:0] ex_alu_res;
  logic [15:0] ex_store_data;
  logic [2:0]  ex_dest;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_wb_en;

  logic        rst_a, rst_b;
  logic        stall_a, stall_b;
  logic [15:0] alu_a, alu_b, mem_a, mem_b;
  logic [2:0]  dest_a, dest_b;
  logic        abm_a, abm_b, wb_a, wb_b;

  logic        o_stall;
  logic [15:0] o_alu, o_mem;
  logic [2:0]  o_dest;
  logic        o_abm, o_wb;

  // Only the selected DUT runs; the other is held in reset
  assign rst_a = rst | sel;
  assign rst_b = rst | ~sel;

  mem_stage #(.ADDR_W(8), .MEM_LAT(2)) dut_lat2 (
    .clk(clk), .rst(rst_a), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .stall(stall_a),
    .alu_res(alu_a), .mem_res(mem_a), .mem_wb_dest(dest_a),
    .alu_bar_mem(abm_a), .wb_en(wb_a)
  );

  mem_stage #(.ADDR_W(8), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst_b), .ex_valid(ex_valid), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_wb_en(ex_wb_en), .stall(stall_b),
    .alu_res(alu_b), .mem_res(mem_b), .mem_wb_dest(dest_b),
    .alu_bar_mem(abm_b), .wb_en(wb_b)
  );

  assign o_stall = sel ? stall_b : stall_a;
  assign o_alu   = sel ? alu_b   : alu_a;
  assign o_mem   = sel ? mem_b   : mem_a;
  assign o_dest  = sel ? dest_b  : dest_a;
  assign o_abm   = sel ? abm_b   : abm_a;
  assign o_wb    = sel ? wb_b    : wb_a;

  int n_vec = 0;
  int n_bad = 0;

  // Reference memory per DUT, word-indexed modulo 256
  logic [15:0] mdl_mem [0:1][0:255];
  bit          mdl_vld [0:1][0:255];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [15:0] a, input logic [15:0] m,
                            input logic [2:0] d, input logic b, input logic w);
    check({tag, ".alu_res"},     o_alu,              a);
    check({tag, ".mem_res"},     o_mem,              m);
    check({tag, ".mem_wb_dest"}, {13'b0, o_dest},    {13'b0, d});
    check({tag, ".alu_bar_mem"}, {15'b0, o_abm},     {15'b0, b});
    check({tag, ".wb_en"},       {15'b0, o_wb},      {15'b0, w});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] addr, input logic [15:0] data,
                       input logic [2:0] dest, input bit rd, input bit wr, input bit wb);
    ex_valid      = v;
    ex_alu_res    = addr;
    ex_store_data = data;
    ex_dest       = dest;
    ex_mem_read   = rd;
    ex_mem_write  = wr;
    ex_wb_en      = wb;
  endtask

  // Presents one instruction, holds it through any stall, checks the result
  task automatic issue(input string tag, input bit v, input logic [15:0] addr,
                       input logic [15:0] data, input logic [2:0] dest,
                       input bit rd, input bit wr, input bit wb);
    int          lat;
    int          ix;
    logic [15:0] ea, em;
    logic [2:0]  ed;
    logic        eb, ew;
    lat = sel ? 1 : 2;
    ix  = int'(addr[7:0]);
    drive(v, addr, data, dest, rd, wr, wb);
    #1;
    if (v && (rd || wr)) begin
      for (int k = 0; k < lat; k++) begin
        check({tag, ".stall_hi"}, {15'b0, o_stall}, 16'h0001);
        step();
        check_outs({tag, ".bubble"}, 16'h0, 16'h0, 3'h0, 1'b0, 1'b0);
      end
    end
    check({tag, ".stall_lo"}, {15'b0, o_stall}, 16'h0000);
    ea = 16'h0; em = 16'h0; ed = 3'h0; eb = 1'b0; ew = 1'b0;
    if (v) begin
      if (wr) begin
        mdl_mem[sel][ix] = data;
        mdl_vld[sel][ix] = 1'b1;
      end else if (rd) begin
        ea = addr; em = mdl_mem[sel][ix]; ed = dest; eb = 1'b1; ew = wb;
      end else begin
        ea = addr; ed = dest; ew = wb;
      end
    end
    step();
    check_outs(tag, ea, em, ed, eb, ew);
  endtask

  task automatic run_random(input int n);
    int          kind;
    bit          v, rd, wr;
    logic [15:0] a, d;
    for (int i = 0; i < n; i++) begin
      kind = int'($urandom_range(0, 4));
      v    = ($urandom_range(0, 5) != 0);
      a    = 16'($urandom);
      d    = 16'($urandom);
      rd   = (kind >= 3) || (kind == 2);
      wr   = (kind == 1) || (kind == 2);
      if (rd && !wr && v && !mdl_vld[sel][a[7:0]]) begin
        wr = 1'b1;
      end
      issue("rand", v, a, d, 3'($urandom), rd, wr, 1'($urandom));
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 256; w++) begin
        mdl_mem[s][w] = 16'h0;
        mdl_vld[s][w] = 1'b0;
      end
    end

    sel = 1'b0;
    rst = 1'b1;
    drive(1'b1, 16'h0040, 16'h0, 3'h1, 1'b1, 1'b0, 1'b1);
    #1;
    check("rst.stall_forced", {15'b0, o_stall}, 16'h0000);
    step();
    step();
    check_outs("rst", 16'h0, 16'h0, 3'h0, 1'b0, 1'b0);
    check("rst.stall", {15'b0, o_stall}, 16'h0000);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);

    issue("alu_op",      1'b1, 16'h1234, 16'hFFFF, 3'h5, 1'b0, 1'b0, 1'b1);
    issue("store_beef",  1'b1, 16'h0010, 16'hBEEF, 3'h2, 1'b0, 1'b1, 1'b1);
    issue("load_beef",   1'b1, 16'h0010, 16'h0000, 3'h3, 1'b1, 1'b0, 1'b1);
    issue("bubble1",     1'b0, 16'hAAAA, 16'h5555, 3'h7, 1'b1, 1'b0, 1'b1);
    issue("store_wrap",  1'b1, 16'h0105, 16'h0A0A, 3'h1, 1'b0, 1'b1, 1'b0);
    issue("bubble2",     1'b0, 16'h0105, 16'h1111, 3'h6, 1'b0, 1'b0, 1'b1);
    issue("load_wrap",   1'b1, 16'h0005, 16'h0000, 3'h4, 1'b1, 1'b0, 1'b1);
    issue("rdwr_store",  1'b1, 16'h0020, 16'h7777, 3'h6, 1'b1, 1'b1, 1'b1);
    issue("load_rdwr",   1'b1, 16'h0020, 16'h0000, 3'h2, 1'b1, 1'b0, 1'b1);
    issue("preload_30",  1'b1, 16'h0030, 16'h1111, 3'h0, 1'b0, 1'b1, 1'b0);

    drive(1'b1, 16'h0030, 16'h5555, 3'h1, 1'b0, 1'b1, 1'b1);
    #1;
    check("abort.accept_stall", {15'b0, o_stall}, 16'h0001);
    step();
    rst = 1'b1;
    #1;
    check("abort.stall_in_rst", {15'b0, o_stall}, 16'h0000);
    step();
    check_outs("abort", 16'h0, 16'h0, 3'h0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    issue("post_abort_alu", 1'b1, 16'h00AB, 16'h0, 3'h7, 1'b0, 1'b0, 1'b1);
    issue("load_30",        1'b1, 16'h0030, 16'h0, 3'h5, 1'b1, 1'b0, 1'b1);

    run_random(150);

    rst = 1'b1;
    sel = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 3'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b0;
    check_outs("rst_lat1", 16'h0, 16'h0, 3'h0, 1'b0, 1'b0);

    issue("l1_store",   1'b1, 16'h0044, 16'hC0DE, 3'h1, 1'b0, 1'b1, 1'b1);
    issue("l1_bubble",  1'b0, 16'h0044, 16'h0, 3'h3, 1'b1, 1'b0, 1'b1);
    issue("l1_load",    1'b1, 16'h0044, 16'h0, 3'h3, 1'b1, 1'b0, 1'b1);
    issue("l1_alu",     1'b1, 16'hFEDC, 16'h0, 3'h7, 1'b0, 1'b0, 1'b0);
    issue("l1_load_b2b",1'b1, 16'h0144, 16'h0, 3'h2, 1'b1, 1'b0, 1'b0);

    run_random(150);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
